bc_filter_bank: RTL and testbench
=================================

Name: bc_filter_bank

Overview:
- Four-channel binary-computed (BC) FIR filter bank. It is the conventional fixed-point reference for the stochastic-computing FIR work.
- One shared 19-tap delay line of 9-bit signed samples feeds four 19-tap coefficient banks. Each bank produces one 9-bit signed output lane.
- Each rising edge of the sampling clock consumes one input sample.

Parameters:
- N, 8, magnitude bits; sample/output width is N+1 (two's complement).
- ORDER, 18, filter order.
- LENGTH, 19, taps per bank (ORDER+1).
- BANKS, 4, number of filters/output lanes.
- CW, 9, coefficient width, signed Q1.8 (value/256).

Ports:
- clock  in  1  sampling clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in  in  N+1 (9)  input sample, signed two's complement.
- out  out  (N+1)*BANKS (36)  four concatenated signed lanes; lane b occupies out[9b+8:9b], so lane 0 is out[8:0].

Behaviour:
- Reset asserted: delay line x[0..18] = 0 and out = 0 immediately, independent of clock. Held while asserted.
- Reset is released synchronously internally; the first edge after deassertion is a normal sample edge.
- On each rising edge (not in reset): x[0] <= in, and x[k] <= x[k-1] for k = 1..18.
- In the same edge, each lane register is loaded with y_b = sat9( (sum over k=0..18 of COEF[b][k]*s_k) >>> 8 ).
  - s_0 = current in; s_k = x[k-1] before the shift.
  - Output is registered, so an input sample affects out one edge after it is applied.
- Arithmetic:
  - Products are 18-bit signed (9x9).
  - Accumulator is 23-bit signed, wide enough for 19 products with no overflow.
  - The shift is arithmetic, truncating toward minus infinity.
  - sat9 clamps to [-256, +255].
- No handshake; every edge is a valid sample. Input is sampled only at the edge.
- Reset mid-stream discards all history; outputs rebuild from zero history.
- Coefficients are compile-time constants and cannot be changed at runtime.
  - Banks 0/1/2 are the symmetric lowpass/bandpass/highpass sets defined in the package.
  - Bank 3 is COEF[3][9] = 128 with all other bank-3 taps 0, i.e. a 9-sample delay at half gain. It serves as the calibration lane.

Decomposition:
- Package bc_fir_pkg holds:
  - constants N, ORDER, LENGTH, BANKS, CW, ACC_W = 23;
  - typedefs sample_t (logic signed [8:0]), coef_t, acc_t;
  - the constant array COEF[BANKS][LENGTH];
  - a sat9 function.
- One sub-module, bc_fir_mac: combinational 19-tap multiply-accumulate, scale and saturate for one bank.
  - It is instantiated BANKS times from a generate loop.
  - The top owns the delay line and output registers.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with nonzero history -> out = 0 immediately. After release with in = 0, out stays 0.
- Impulse: apply in = -256 for one edge, then 0 -> lane b equals -COEF[b][k] (saturated to 255 if COEF = -256) on the (k+1)-th edge, k = 0..18. All lanes return to 0 after 19 edges.
- Calibration lane: hold in = 100 -> lane 3 reads 0 for edges 1..9, then 50 from edge 10 onward.
  - Also hold in = -3 -> lane 3 reaches -2 (floor of -1.5).
- Saturation: hold in = 255 with a bank whose positive coefficient sum exceeds 256 -> that lane clamps at 255.
  - Hold in = -256 -> that lane clamps at -256, with no wrap.
- Ramp sweep: start at in = 3, add 4 every edge with 9-bit wrap, for 4096 edges -> every lane matches a bit-exact software model of the equation above on every edge.

Source files
------------

// File: rtl/bc_fir_pkg.sv
// Shared constants, types, coefficient banks and saturation helper for the
// four-channel binary-computed FIR filter bank.
package bc_fir_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned ORDER  = 18;
  localparam int unsigned LENGTH = ORDER + 1;
  localparam int unsigned BANKS  = 4;
  localparam int unsigned CW     = 9;
  localparam int unsigned ACC_W  = 23;
  localparam int unsigned SW     = N + 1;   // sample / lane width
  localparam int unsigned FRAC   = 8;       // Q1.8 coefficient fraction bits

  typedef logic signed [SW-1:0]    sample_t;
  typedef logic signed [CW-1:0]    coef_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = 23'sd255;
  localparam acc_t SAT_MIN = -23'sd256;

  // Bank 0 lowpass (DC gain > 1), 1 bandpass, 2 highpass, 3 calibration delay.
  localparam coef_t COEF [BANKS][LENGTH] = '{
    '{-9'sd4, -9'sd6, -9'sd5, 9'sd0, 9'sd10, 9'sd24, 9'sd40, 9'sd56, 9'sd68,
      9'sd72,
      9'sd68, 9'sd56, 9'sd40, 9'sd24, 9'sd10, 9'sd0, -9'sd5, -9'sd6, -9'sd4},
    '{9'sd2, 9'sd0, -9'sd8, -9'sd12, 9'sd0, 9'sd20, 9'sd28, 9'sd0, -9'sd48,
      -9'sd60,
      -9'sd48, 9'sd0, 9'sd28, 9'sd20, 9'sd0, -9'sd12, -9'sd8, 9'sd0, 9'sd2},
    '{-9'sd2, 9'sd3, -9'sd4, 9'sd5, -9'sd8, 9'sd11, -9'sd16, 9'sd26, -9'sd56,
      9'sd200,
      -9'sd56, 9'sd26, -9'sd16, 9'sd11, -9'sd8, 9'sd5, -9'sd4, 9'sd3, -9'sd2},
    '{9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0,
      9'sd128,
      9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0, 9'sd0}
  };

  // Clamp a scaled accumulator into the signed 9-bit lane range.
  function automatic sample_t sat9(input acc_t a);
    if (a > SAT_MAX)      return sample_t'(SAT_MAX[SW-1:0]);
    else if (a < SAT_MIN) return sample_t'(SAT_MIN[SW-1:0]);
    else                  return sample_t'(a[SW-1:0]);
  endfunction

endpackage

// File: rtl/bc_filter_bank_if.sv
// Sample/lane bus of the filter bank.
//   in  : signed input sample, driven by the master
//   out : four concatenated signed lanes, lane b at out[9b+8:9b]
interface bc_filter_bank_if;
  import bc_fir_pkg::*;

  sample_t                in;
  logic [SW*BANKS-1:0]    out;

  modport master (output in, input out);
  modport slave  (input in, output out);
endinterface

// File: rtl/bc_fir_mac.sv
// Combinational 19-tap multiply-accumulate, Q1.8 scale and saturate for one
// coefficient bank.
//   taps : s_0 (current input) .. s_18 (oldest sample)
//   y_c  : saturated lane value (combinational)
module bc_fir_mac
  import bc_fir_pkg::*;
#(
  parameter int unsigned BANK = 0
) (
  input  sample_t taps [LENGTH],
  output sample_t y_c
);

  localparam int unsigned PW = SW + CW;

  logic signed [PW-1:0] prod;
  acc_t                 acc;
  acc_t                 scaled;

  // 9x9 products are exact in 18 bits; 23-bit sum of 19 of them cannot overflow.
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int unsigned k = 0; k < LENGTH; k++) begin
      prod = PW'(taps[k]) * PW'(COEF[BANK][k]);
      acc  = acc + ACC_W'(prod);
    end
    scaled = acc >>> FRAC;   // floor toward minus infinity
    y_c    = sat9(scaled);
  end

endmodule

// File: rtl/bc_filter_bank.sv
// Four-channel binary-computed FIR filter bank: one shared delay line feeds
// four constant-coefficient MACs whose results are registered per lane.
//   clock : sampling clock, one sample per rising edge
//   reset : asynchronous active-high clear of history and outputs
//   bus   : slave side of the sample/lane bus (in, out)
module bc_filter_bank
  import bc_fir_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  bc_filter_bank_if.slave   bus
);

  // Only ORDER samples need storing: tap 0 is the sample arriving this edge.
  sample_t             x [ORDER];
  sample_t             taps [LENGTH];
  sample_t             y_c [BANKS];
  logic [SW*BANKS-1:0] out_r;

  // Tap vector as seen just before the edge shifts the line.
  always_comb begin
    taps[0] = bus.in;
    for (int unsigned k = 1; k < LENGTH; k++) begin
      taps[k] = x[k-1];
    end
  end

  // One MAC per coefficient bank.
  generate
    for (genvar b = 0; b < int'(BANKS); b++) begin : g_bank
      bc_fir_mac #(.BANK(b)) u_mac (
        .taps (taps),
        .y_c  (y_c[b])
      );
    end
  endgenerate

  // Delay line and lane registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < ORDER; k++) begin
        x[k] <= '0;
      end
      out_r <= '0;
    end else begin
      x[0] <= bus.in;
      for (int unsigned k = 1; k < ORDER; k++) begin
        x[k] <= x[k-1];
      end
      for (int unsigned b = 0; b < BANKS; b++) begin
        out_r[b*SW +: SW] <= y_c[b];
      end
    end
  end

  assign bus.out = out_r;

endmodule

// File: tb/tb_bc_filter_bank.sv
// Self-checking bench for bc_filter_bank: calibration table, impulse, reset
// and saturation sequences, plus random and ramp sweeps against a
// floor-division reference model.
module tb_bc_filter_bank;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  bc_filter_bank_if bus ();

  bc_filter_bank dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Independent transcription of the coefficient banks.
  int coef [4][19] = '{
    '{-4, -6, -5, 0, 10, 24, 40, 56, 68, 72, 68, 56, 40, 24, 10, 0, -5, -6, -4},
    '{2, 0, -8, -12, 0, 20, 28, 0, -48, -60, -48, 0, 28, 20, 0, -12, -8, 0, 2},
    '{-2, 3, -4, 5, -8, 11, -16, 26, -56, 200, -56, 26, -16, 11, -8, 5, -4, 3, -2},
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 128, 0, 0, 0, 0, 0, 0, 0, 0, 0}
  };

  // hist[0] is the sample taken on the latest edge, hist[18] the oldest.
  int hist [19];

  typedef struct {
    int in_val;
    int exp3;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lane(input int b);
    logic signed [8:0] t;
    t = bus.out[b*9 +: 9];
    return int'(t);
  endfunction

  // y = clamp(floor(sum / 256)) computed with plain integer division.
  function automatic int model(input int b);
    int acc;
    int q;
    acc = 0;
    for (int k = 0; k < 19; k++) acc += coef[b][k] * hist[k];
    q = acc / 256;
    if ((acc % 256 != 0) && (acc < 0)) q -= 1;
    if (q > 255)  q = 255;
    if (q < -256) q = -256;
    return q;
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 19; k++) hist[k] = 0;
  endfunction

  // Apply one sample, clock it, and compare every lane with the model.
  task automatic step(input int v, input string tag);
    bus.in = 9'(v);
    @(posedge clock);
    #1;
    for (int k = 18; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    for (int b = 0; b < 4; b++)
      check($sformatf("%s_lane%0d", tag, b), lane(b), model(b));
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    bus.in = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    logic [8:0] r;
    tests  = 0;
    fails  = 0;
    reset  = 1'b1;
    bus.in = '0;
    clear_model();

    // Reset state.
    repeat (2) @(negedge clock);
    for (int b = 0; b < 4; b++) check($sformatf("rst_lane%0d", b), lane(b), 0);
    reset = 1'b0;

    // Calibration lane table: 100 held, then -3 held.
    for (int i = 0; i < 12; i++) vecs.push_back('{100, (i < 9) ? 0 : 50});
    for (int i = 0; i < 10; i++) vecs.push_back('{-3, (i < 9) ? 50 : -2});
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in_val, "cal");
      check($sformatf("cal_vec%0d", i), lane(3), vecs[i].exp3);
    end

    // Impulse of -256 reads out negated coefficients in order.
    do_reset();
    for (int k = 0; k < 19; k++) begin
      step((k == 0) ? -256 : 0, "imp");
      for (int b = 0; b < 4; b++)
        check($sformatf("imp_b%0d_k%0d", b, k), lane(b),
              (coef[b][k] == -256) ? 255 : -coef[b][k]);
    end
    step(0, "imp_tail");
    for (int b = 0; b < 4; b++) check($sformatf("imp_zero%0d", b), lane(b), 0);

    // Saturation on the lowpass lane, both rails.
    do_reset();
    for (int i = 0; i < 19; i++) step(255, "satp");
    check("sat_pos", lane(0), 255);
    for (int i = 0; i < 19; i++) step(-256, "satn");
    check("sat_neg", lane(0), -256);

    // Random stimulus, then asynchronous reset mid-cycle with live history.
    for (int i = 0; i < 300; i++) step(int'($urandom_range(0, 511)) - 256, "rnd");
    #2;
    reset = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) check($sformatf("arst_lane%0d", b), lane(b), 0);
    @(posedge clock);
    #1;
    for (int b = 0; b < 4; b++) check($sformatf("arst_hold%0d", b), lane(b), 0);
    @(negedge clock);
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 20; i++) begin
      step(0, "post_rst");
      for (int b = 0; b < 4; b++) check($sformatf("post_rst_zero%0d", b), lane(b), 0);
    end

    // Ramp sweep with 9-bit wrap.
    r = 9'd3;
    for (int i = 0; i < 4096; i++) begin
      step(int'($signed(r)), "ramp");
      r = r + 9'd4;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
